// File: rtl/chien_consts_pkg.sv
// Shared constants and types for the RS(544,522) Chien back-end.
package chien_consts_pkg;

  localparam int unsigned W      = 10;    // GF(2^10) symbol width
  localparam int unsigned T      = 11;    // correction capability
  localparam int unsigned P      = 32;    // Chien lanes per cycle
  localparam int unsigned N      = 1023;  // GF multiplicative group order
  localparam int unsigned N_CW   = 544;   // codeword length n

  localparam int unsigned POS_W  = $clog2(N);
  localparam int unsigned DEG_W  = $clog2(T + 2);
  localparam int unsigned CNT_W  = $clog2(T + 1);
  localparam int unsigned IDX_W  = $clog2(T);
  // Running slot index can reach T + P before hits are dropped.
  localparam int unsigned SLOT_W = $clog2(T + P + 1);

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [W-1:0]     dodd;
  } err_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK,
    DRAIN
  } errcol_state_e;

  // x*sigma'(x) in characteristic 2: only odd-degree terms survive.
  function automatic logic [W-1:0] odd_term_sum(input logic [T:0][W-1:0] terms);
    logic [W-1:0] acc;
    acc = '0;
    for (int unsigned k = 1; k <= T; k += 2) begin
      acc ^= terms[k];
    end
    return acc;
  endfunction

endpackage

// File: rtl/chien_hit_compact.sv
// Prefix-count compaction: assigns each hitting lane its list slot.
module chien_hit_compact
  import chien_consts_pkg::*;
(
  input  logic [P-1:0]             hit_i,
  input  logic [CNT_W-1:0]         base_i,
  output logic [P-1:0][SLOT_W-1:0] slot_o,
  output logic [SLOT_W-1:0]        cnt_o
);

  // Running sum over lanes in ascending order; slot is the count before the lane.
  always_comb begin
    logic [SLOT_W-1:0] run;
    run    = SLOT_W'(base_i);
    slot_o = '0;
    for (int unsigned l = 0; l < P; l++) begin
      slot_o[l] = run;
      run       = run + SLOT_W'(hit_i[l]);
    end
    cnt_o = run;
  end

endmodule

// File: rtl/chien_err_collector.sv
// Chien error collector: compacts per-lane root hits into an error list,
// checks the count against deg(sigma) and streams entries to Forney.
// Optional macro ERRCOL_FAIL_CNT_EN adds a saturating failed-codeword counter.
module chien_err_collector
  import chien_consts_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        scan_start_i,
  input  logic [DEG_W-1:0]            sigma_deg_i,
  input  logic                        hit_valid_i,
  input  logic                        scan_done_i,
  input  logic [P-1:0]                hit_mask_i,
  input  logic [P-1:0][T:0][W-1:0]    u_vec_i,
  input  logic [P-1:0][POS_W-1:0]     pos_bus_i,
  output logic                        err_valid_o,
  input  logic                        err_ready_i,
  output logic [POS_W-1:0]            err_pos_o,
  output logic [W-1:0]                err_dodd_o,
  output logic                        err_last_o,
  output logic [CNT_W-1:0]            err_cnt_o,
  output logic                        fail_o,
  output logic                        done_o,
  output logic                        busy_o
`ifdef ERRCOL_FAIL_CNT_EN
  ,
  output logic [15:0]                 fail_cnt_o
`endif
);

  localparam logic [SLOT_W-1:0] T_SLOT    = SLOT_W'(T);
  localparam logic [CNT_W-1:0]  T_CNT     = CNT_W'(T);
  localparam logic [DEG_W-1:0]  T_DEG     = DEG_W'(T);
  localparam logic [POS_W-1:0]  POS_LIMIT = POS_W'(N_CW);

  errcol_state_e state_q, state_d;

  err_entry_t             list_q [T];
  err_entry_t             list_d [T];
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   ovf_q;
  logic [DEG_W-1:0]       deg_q;
  logic [IDX_W-1:0]       rd_ptr_q;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;

  logic [P-1:0]              hit_qual;
  logic [P-1:0][SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]         cnt_new;
  logic                      ovf_now;
  logic                      capture_en;
  logic                      check_fail;
  logic [IDX_W-1:0]          last_idx;
  err_entry_t                cur;

  // Qualify lane hits: root found and position inside the shortened codeword.
  always_comb begin
    hit_qual = '0;
    for (int unsigned l = 0; l < P; l++) begin
      hit_qual[l] = hit_mask_i[l] && (pos_bus_i[l] < POS_LIMIT);
    end
  end

  chien_hit_compact u_compact (
    .hit_i  (hit_qual),
    .base_i (cnt_q),
    .slot_o (slot),
    .cnt_o  (cnt_new)
  );

  assign capture_en = (state_q == COLLECT) && hit_valid_i && !scan_start_i;
  assign ovf_now    = (cnt_new > T_SLOT);
  assign cnt_d      = ovf_now ? T_CNT : cnt_new[CNT_W-1:0];
  assign last_idx   = IDX_W'(cnt_q - CNT_W'(1));
  assign check_fail = ovf_q || (deg_q > T_DEG) || (DEG_W'(cnt_q) != deg_q);

  // Scatter qualified hits into their compacted slots; slots past T are dropped.
  always_comb begin
    list_d = list_q;
    for (int unsigned l = 0; l < P; l++) begin
      if (hit_qual[l] && (slot[l] < T_SLOT)) begin
        list_d[slot[l][IDX_W-1:0]].pos  = pos_bus_i[l];
        list_d[slot[l][IDX_W-1:0]].dodd = odd_term_sum(u_vec_i[l]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and end-of-codeword status; a start pulse aborts from any state.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    if (scan_start_i) begin
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        COLLECT: if (scan_done_i) state_d = CHECK;
        CHECK: begin
          if (check_fail || (cnt_q == '0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            fail_d  = check_fail;
          end else begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (err_ready_i && (rd_ptr_q == last_idx)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // List, counters, latched degree, drain pointer and status pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < T; i++) begin
        list_q[i] <= '0;
      end
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      deg_q    <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      done_q <= done_d;
      fail_q <= fail_d;
      if (scan_start_i) begin
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        deg_q    <= sigma_deg_i;
        rd_ptr_q <= '0;
      end else begin
        if (capture_en) begin
          list_q <= list_d;
          cnt_q  <= cnt_d;
          if (ovf_now) ovf_q <= 1'b1;
        end
        // Pointer stops on the last entry so it never indexes past the list.
        if ((state_q == DRAIN) && err_ready_i && (rd_ptr_q != last_idx)) begin
          rd_ptr_q <= rd_ptr_q + IDX_W'(1);
        end
      end
    end
  end

`ifdef ERRCOL_FAIL_CNT_EN
  logic [15:0] fail_cnt_q;

  // Saturating count of failed codewords, stepped on the failing done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_cnt_q <= '0;
    end else if (done_q && fail_q && (fail_cnt_q != '1)) begin
      fail_cnt_q <= fail_cnt_q + 16'd1;
    end
  end

  assign fail_cnt_o = fail_cnt_q;
`endif

  assign cur         = list_q[rd_ptr_q];
  assign err_valid_o = (state_q == DRAIN);
  assign err_pos_o   = err_valid_o ? cur.pos  : '0;
  assign err_dodd_o  = err_valid_o ? cur.dodd : '0;
  assign err_last_o  = err_valid_o && (rd_ptr_q == last_idx);
  assign err_cnt_o   = cnt_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_chien_err_collector.sv
// Directed bench for chien_err_collector.
module tb_chien_err_collector;
  import chien_consts_pkg::*;

  logic                      clk_i;
  logic                      rst_ni;
  logic                      scan_start_i;
  logic [DEG_W-1:0]          sigma_deg_i;
  logic                      hit_valid_i;
  logic                      scan_done_i;
  logic [P-1:0]              hit_mask_i;
  logic [P-1:0][T:0][W-1:0]  u_vec_i;
  logic [P-1:0][POS_W-1:0]   pos_bus_i;
  logic                      err_valid_o;
  logic                      err_ready_i;
  logic [POS_W-1:0]          err_pos_o;
  logic [W-1:0]              err_dodd_o;
  logic                      err_last_o;
  logic [CNT_W-1:0]          err_cnt_o;
  logic                      fail_o;
  logic                      done_o;
  logic                      busy_o;
`ifdef ERRCOL_FAIL_CNT_EN
  logic [15:0]               fail_cnt_o;
`endif

  chien_err_collector dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .scan_start_i (scan_start_i),
    .sigma_deg_i  (sigma_deg_i),
    .hit_valid_i  (hit_valid_i),
    .scan_done_i  (scan_done_i),
    .hit_mask_i   (hit_mask_i),
    .u_vec_i      (u_vec_i),
    .pos_bus_i    (pos_bus_i),
    .err_valid_o  (err_valid_o),
    .err_ready_i  (err_ready_i),
    .err_pos_o    (err_pos_o),
    .err_dodd_o   (err_dodd_o),
    .err_last_o   (err_last_o),
    .err_cnt_o    (err_cnt_o),
    .fail_o       (fail_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
`ifdef ERRCOL_FAIL_CNT_EN
    ,
    .fail_cnt_o   (fail_cnt_o)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  int                m_hits;
  int                m_deg;
  int                m_fails = 0;
  logic [POS_W-1:0]  q_pos[$];
  logic [W-1:0]      q_dodd[$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [W-1:0] exp_dodd(input int l);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k <= int'(T); k++) begin
      if (k % 2 == 1) acc ^= u_vec_i[l][k];
    end
    return acc;
  endfunction

  task automatic set_u(input int seed);
    for (int l = 0; l < int'(P); l++) begin
      for (int k = 0; k <= int'(T); k++) begin
        u_vec_i[l][k] = W'((k * k + 37 * l + 5 * seed) % 1024);
      end
    end
  endtask

  task automatic set_pos_default();
    for (int l = 0; l < int'(P); l++) pos_bus_i[l] = POS_W'(l * 17);
  endtask

  task automatic start_word(input int deg);
    scan_start_i = 1'b1;
    sigma_deg_i  = DEG_W'(deg);
    m_deg        = deg;
    m_hits       = 0;
    q_pos.delete();
    q_dodd.delete();
    tick();
    scan_start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_cnt", err_cnt_o, 0);
  endtask

  task automatic hit_cycle(input logic [P-1:0] mask, input bit with_done);
    hit_mask_i  = mask;
    hit_valid_i = 1'b1;
    scan_done_i = with_done;
    for (int l = 0; l < int'(P); l++) begin
      if (mask[l] && (int'(pos_bus_i[l]) < 544)) begin
        if (m_hits < int'(T)) begin
          q_pos.push_back(pos_bus_i[l]);
          q_dodd.push_back(exp_dodd(l));
        end
        m_hits++;
      end
    end
    tick();
    hit_valid_i = 1'b0;
    hit_mask_i  = '0;
    scan_done_i = 1'b0;
  endtask

  task automatic finish_word(input bit done_already, input int stall_at);
    int  exp_cnt;
    bit  exp_fail;
    exp_cnt  = (m_hits > int'(T)) ? int'(T) : m_hits;
    exp_fail = (m_hits > int'(T)) || (m_deg > int'(T)) || (exp_cnt != m_deg);
    if (!done_already) begin
      scan_done_i = 1'b1;
      tick();
      scan_done_i = 1'b0;
    end
    chk("chk_valid", err_valid_o, 0);
    chk("chk_done", done_o, 0);
    chk("chk_cnt", err_cnt_o, exp_cnt);
    tick();
    if (exp_fail || exp_cnt == 0) begin
      if (exp_fail) m_fails++;
      chk("end_done", done_o, 1);
      chk("end_fail", fail_o, exp_fail);
      chk("end_valid", err_valid_o, 0);
      chk("end_cnt", err_cnt_o, exp_cnt);
      tick();
      chk("done_pulse", done_o, 0);
      chk("idle_busy", busy_o, 0);
    end else begin
      for (int i = 0; i < exp_cnt; i++) begin
        chk("ent_valid", err_valid_o, 1);
        chk("ent_pos", err_pos_o, q_pos[i]);
        chk("ent_dodd", err_dodd_o, q_dodd[i]);
        chk("ent_last", err_last_o, (i == exp_cnt - 1));
        chk("ent_done", done_o, 0);
        if (i == stall_at) begin
          err_ready_i = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            chk("stall_valid", err_valid_o, 1);
            chk("stall_pos", err_pos_o, q_pos[i]);
            chk("stall_dodd", err_dodd_o, q_dodd[i]);
          end
          err_ready_i = 1'b1;
        end
        tick();
      end
      chk("drain_done", done_o, 1);
      chk("drain_fail", fail_o, 0);
      chk("drain_valid", err_valid_o, 0);
      chk("drain_cnt", err_cnt_o, exp_cnt);
      tick();
      chk("done_pulse", done_o, 0);
      chk("idle_busy", busy_o, 0);
    end
`ifdef ERRCOL_FAIL_CNT_EN
    chk("fail_cnt", fail_cnt_o, m_fails);
`endif
  endtask

  initial begin
    rst_ni       = 1'b0;
    scan_start_i = 1'b0;
    sigma_deg_i  = '0;
    hit_valid_i  = 1'b0;
    scan_done_i  = 1'b0;
    hit_mask_i   = '0;
    err_ready_i  = 1'b1;
    set_u(0);
    set_pos_default();
    repeat (3) tick();

    // Reset state
    chk("rst_valid", err_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_fail", fail_o, 0);
    chk("rst_cnt", err_cnt_o, 0);
    chk("rst_pos", err_pos_o, 0);
    rst_ni = 1'b1;
    tick();

    // Async reset mid-COLLECT, then a zero-error codeword
    start_word(2);
    hit_cycle(32'h0000_0003, 1'b0);
    chk("pre_rst_cnt", err_cnt_o, 2);
    rst_ni = 1'b0;
    #2;
    chk("arst_busy", busy_o, 0);
    chk("arst_cnt", err_cnt_o, 0);
    tick();
    rst_ni  = 1'b1;
    m_fails = 0;
    tick();
    start_word(0);
    finish_word(1'b0, -1);

    // 1: two hits in separate cycles; pos 544 on another lane is ignored
    set_u(1);
    start_word(2);
    pos_bus_i[3] = 10'd530;
    pos_bus_i[4] = 10'd544;
    hit_cycle(32'h0000_0018, 1'b0);
    pos_bus_i[10] = 10'd7;
    hit_cycle(32'h0000_0400, 1'b0);
    finish_word(1'b0, -1);

    // 2: three hits in one cycle, captured alongside scan_done
    set_u(2);
    set_pos_default();
    pos_bus_i[0]  = 10'd100;
    pos_bus_i[5]  = 10'd200;
    pos_bus_i[31] = 10'd543;
    start_word(3);
    hit_cycle(32'h8000_0021, 1'b1);
    finish_word(1'b1, -1);

    // 3: deg 2 with a single hit
    set_pos_default();
    start_word(2);
    hit_cycle(32'h0000_0100, 1'b0);
    finish_word(1'b0, -1);

    // 4: 12 qualified hits against deg 11, lanes 1 and 3 out of range
    set_u(4);
    pos_bus_i[1] = 10'd600;
    pos_bus_i[3] = 10'd1000;
    start_word(11);
    hit_cycle(32'h0000_3FFF, 1'b0);
    finish_word(1'b0, -1);

    // 5: four entries across two cycles, ready low for 5 cycles on entry 1
    set_u(5);
    set_pos_default();
    start_word(4);
    hit_cycle(32'h0000_0204, 1'b0);
    hit_cycle(32'h0010_0002, 1'b0);
    finish_word(1'b0, 1);

    // 6: abort during DRAIN, then a clean codeword
    start_word(2);
    hit_cycle(32'h0000_00C0, 1'b0);
    scan_done_i = 1'b1;
    tick();
    scan_done_i = 1'b0;
    tick();
    chk("abort_drain_valid", err_valid_o, 1);
    tick();
    start_word(1);
    chk("abort_done", done_o, 0);
    chk("abort_valid", err_valid_o, 0);
    set_u(6);
    pos_bus_i[12] = 10'd300;
    hit_cycle(32'h0000_1000, 1'b0);
    finish_word(1'b0, -1);

    // deg above T fails even with no hits
    start_word(12);
    finish_word(1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
